// File: rtl/shift_pkg.sv
// Shared definitions for the iterative right shifter.
// Holds datapath widths and the controller state type.
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    // Step-count width: must hold 0..32.
    localparam int CNT_W   = SHAMT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

endpackage

// File: rtl/shift_right_step.sv
// Combinational single-iteration right shift with a chosen fill bit.
// Ports: data (in), cnt 0..32 (in), fill (in), result (out).
import shift_pkg::*;

module shift_right_step (
    input  logic [XLEN-1:0]  data,
    input  logic [CNT_W-1:0] cnt,
    input  logic             fill,
    output logic [XLEN-1:0]  result
);

    logic [2*XLEN-1:0] wide;

    // Fill bits sit above the operand and slide into the vacated MSBs.
    always_comb begin
        wide   = {{XLEN{fill}}, data} >> cnt;
        result = wide[XLEN-1:0];
    end

endmodule

// File: rtl/shift_right_iter.sv
// Multi-cycle SRL/SRA shifter, STEP bit positions per clock.
// Ports: i_clk, i_rst (sync, active high); request i_valid/o_ready
// with i_data, amount, i_arith; response o_valid/i_ready with
// o_data; o_busy high while SHIFT or DONE.
// Build option: define SHIFT_RIGHT_SRA_EN to honour i_arith (SRA).
import shift_pkg::*;

module shift_right_iter #(
    parameter int STEP = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [XLEN-1:0]    i_data,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               i_arith,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [XLEN-1:0]    o_data,
    output logic               o_busy
);

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    shift_state_e       state, state_nxt;
    logic [XLEN-1:0]    data_q;
    logic [SHAMT_W-1:0] rem;
    logic               fill_q;

    logic               fill_in;
    logic [CNT_W-1:0]   rem_w;
    logic [CNT_W-1:0]   step_cnt;
    logic [SHAMT_W-1:0] rem_nxt;
    logic [XLEN-1:0]    shifted;

`ifdef SHIFT_RIGHT_SRA_EN
    assign fill_in = i_arith & i_data[XLEN-1];
`else
    // Logical-only build: the arith request has no effect.
    assign fill_in = i_arith & 1'b0;
`endif

    // Take a full STEP when possible, otherwise finish the remainder.
    always_comb begin
        rem_w    = {1'b0, rem};
        step_cnt = (rem_w >= STEP_C) ? STEP_C : rem_w;
        rem_nxt  = rem - step_cnt[SHAMT_W-1:0];
    end

    shift_right_step u_step (
        .data   (data_q),
        .cnt    (step_cnt),
        .fill   (fill_q),
        .result (shifted)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_valid)
                    state_nxt = (amount == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem_nxt == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                if (i_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= '0;
            rem    <= '0;
            fill_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        data_q <= i_data;
                        rem    <= amount;
                        fill_q <= fill_in;
                    end
                end
                SHIFT: begin
                    data_q <= shifted;
                    rem    <= rem_nxt;
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_busy  = (state != IDLE);
    assign o_data  = data_q;

endmodule

// File: tb/tb_shift_right_iter.sv
// Directed self-checking bench for shift_right_iter (STEP=4).
// Expectations follow the SHIFT_RIGHT_SRA_EN build setting.
module tb_shift_right_iter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic [4:0]  amount;
    logic        i_arith;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_busy;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    shift_right_iter #(.STEP(4)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .amount  (amount),
        .i_arith (i_arith),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_busy  (o_busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic        arith;
        logic [31:0] exp_srl;
        logic [31:0] exp_sra;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input vec_t v);
`ifdef SHIFT_RIGHT_SRA_EN
        return v.exp_sra;
`else
        return v.exp_srl;
`endif
    endfunction

    // Issue a request, count edges until o_valid (bounded).
    task automatic issue(input logic [31:0] d, input logic [4:0] a,
                         input logic ar, output int lat);
        i_data  = d;
        amount  = a;
        i_arith = ar;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_data  = 32'h5555_AAAA;
        amount  = 5'd7;
        i_arith = ~ar;
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        vecs[0] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 32'h0000_0001, 8};
        vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 8};
        vecs[2] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
        vecs[3] = '{32'h1234_5678, 5'd8,  1'b0, 32'h0012_3456, 32'h0012_3456, 2};
        vecs[4] = '{32'hF000_0000, 5'd4,  1'b1, 32'h0F00_0000, 32'hFF00_0000, 1};
        vecs[5] = '{32'h8765_4321, 5'd5,  1'b1, 32'h043B_2A19, 32'hFC3B_2A19, 2};
        vecs[6] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 32'h0000_0000, 8};
        vecs[7] = '{32'hFFFF_FFFF, 5'd16, 1'b1, 32'h0000_FFFF, 32'hFFFF_FFFF, 4};
        vecs[8] = '{32'hA5A5_A5A5, 5'd3,  1'b0, 32'h14B4_B4B4, 32'h14B4_B4B4, 1};

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        amount  = '0;
        i_arith = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data",  o_data,       32'h0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].data, vecs[i].amt, vecs[i].arith, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_data", i), o_data, pick(vecs[i]));
            chk($sformatf("v%0d_busy", i), 32'(o_busy), 32'd1);
            release_result();
            chk($sformatf("v%0d_idle", i), 32'(o_ready), 32'd1);
            chk($sformatf("v%0d_hold", i), o_data, pick(vecs[i]));
        end

        // Backpressure with a new request pending.
        issue(32'h1234_5678, 5'd8, 1'b0, lat);
        chk("bp_lat", 32'(lat), 32'd2);
        held    = o_data;
        i_data  = 32'hF000_0000;
        amount  = 5'd4;
        i_arith = 1'b1;
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk);
            #1;
            chk($sformatf("bp_data%0d", c), o_data, held);
            chk($sformatf("bp_rdy%0d", c), 32'(o_ready), 32'd0);
            chk($sformatf("bp_vld%0d", c), 32'(o_valid), 32'd1);
        end
        chk("bp_result", held, 32'h0012_3456);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk("bp_idle", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        chk("bp_accept", 32'(o_busy), 32'd1);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        chk("bp2_lat", 32'(lat), 32'd1);
`ifdef SHIFT_RIGHT_SRA_EN
        chk("bp2_data", o_data, 32'hFF00_0000);
`else
        chk("bp2_data", o_data, 32'h0F00_0000);
`endif
        release_result();

        // Reset while two steps into a 20-bit shift.
        i_data  = 32'hCAFE_F00D;
        amount  = 5'd20;
        i_arith = 1'b1;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("mid_busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_ready = 1'b0;
        chk("mid_valid", 32'(o_valid), 32'd0);
        chk("mid_data",  o_data,       32'h0);
        chk("mid_ready", 32'(o_ready), 32'd1);
        chk("mid_busy0", 32'(o_busy),  32'd0);

        // Fresh operation after the aborted one.
        issue(32'h8000_0000, 5'd1, 1'b0, lat);
        chk("post_lat",  32'(lat), 32'd1);
        chk("post_data", o_data,   32'h4000_0000);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_right_iter.md
# shift_right_iter

Multi-cycle right shifter for the RV32 execute stage. It implements SRL and SRA (SRLI/SRAI) as the counterpart to the single-cycle left shifter, shifting STEP bit positions per clock to keep the shifter area small. It accepts one operand pair through a valid/ready request port, iterates, then holds the result on a valid/ready response port until the consumer takes it.

## Interface
- STEP, default 4: bit positions shifted per cycle; legal values 1, 2, 4, 8, 16, 32.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  request ready; high only in IDLE.
- i_data  in  32  operand to shift.
- amount  in  5  shift amount, 0..31.
- i_arith  in  1  1 = SRA (sign fill), 0 = SRL (zero fill).
- o_valid  out  1  result valid; high only in DONE.
- i_ready  in  1  consumer accepts the result.
- o_data  out  32  shifted result.
- o_busy  out  1  high in SHIFT or DONE.

## Operation
- States:
  - IDLE: o_ready=1.
  - SHIFT: iterate.
  - DONE: o_valid=1.
- IDLE:
  - i_valid=1 causes an accept on that edge.
  - Accept loads the data register with i_data, rem with amount, and the fill bit with i_arith & i_data[31].
  - If amount==0, next state is DONE; otherwise next state is SHIFT.
- SHIFT, one step per edge:
  - If rem >= STEP: data shifts right by STEP, rem -= STEP.
  - Otherwise: data shifts right by rem, rem = 0.
  - Vacated MSBs take the fill bit.
  - When the updated rem is 0, next state is DONE.
- DONE:
  - o_data holds and is stable.
  - i_ready=1 returns the block to IDLE on that edge.
  - i_valid is ignored, because o_ready=0.
- o_data always reflects the data register. In IDLE it holds the last result, or 0 after reset.
- Width rules:
  - rem is 5 bits and never underflows.
  - The shift never exceeds 31 in total.
  - The SRA result equals $signed(i_data) >>> amount.
  - The SRL result equals i_data >> amount.
- Reset in any state:
  - Next cycle: state=IDLE, rem=0, data register=0.
  - Any in-flight operation is dropped; no partial result is presented.

## Timing
- Reset values: o_ready=1, o_valid=0, o_data=32'h0, o_busy=0.
- o_valid rises ceil(amount/STEP) edges after the accepting edge. For amount==0 it rises on the accepting edge itself.
  - With STEP=4: amount 0 takes 0 edges, 1..4 takes 1, 31 takes 8.
- Result handshake completes on the edge where o_valid & i_ready.
  - o_ready rises in the following cycle.
  - Minimum initiation interval is latency + 2 cycles.
- i_data, amount and i_arith are sampled only on the accepting edge. Later changes have no effect.
- o_ready, o_valid and o_busy are decoded directly from the state register, with no combinational path from the inputs.
- i_rst has priority over every handshake on the same edge.

## Configuration
- SHIFT_RIGHT_SRA_EN:
  - Defined: i_arith selects sign fill as described above.
  - Undefined: i_arith is ignored, the fill bit is always 0, and the block performs SRL only. Latency and handshake are identical in both builds.

## Structure
- The shared package shift_pkg holds:
  - XLEN = 32.
  - SHAMT_W = 5.
  - The state typedef shift_state_e: IDLE, SHIFT, DONE.
- One sub-module is natural: shift_right_step.
  - Purely combinational.
  - Inputs: 32-bit data, a step count 0..STEP, and the fill bit.
  - Output: the shifted data.
  - Instantiated once and used for every iteration.

## Test plan
- SRL, STEP=4, i_data=32'h8000_0000, amount=31:
  - o_data=32'h0000_0001.
  - o_valid rises 8 edges after accept.
- SRA (macro defined), i_data=32'h8000_0000, amount=31:
  - Expect 32'hFFFF_FFFF.
  - Without the macro, expect 32'h0000_0001.
- amount=0, i_data=32'hDEAD_BEEF:
  - o_valid is high in the cycle after accept.
  - o_data=32'hDEAD_BEEF.
- Backpressure:
  - Hold i_ready=0 for 5 cycles in DONE with i_valid=1 and new operands applied.
  - o_data stays stable and o_ready stays 0.
  - After i_ready=1, the new request is accepted in the next IDLE cycle.
- Reset mid-SHIFT (amount=20, after 2 steps):
  - Next cycle: o_valid=0, o_data=0, o_ready=1, o_busy=0.
- SRL i_data=32'h1234_5678, amount=8: expect 32'h0012_3456 after 2 edges.
- SRA i_data=32'hF000_0000, amount=4: expect 32'hFF00_0000 after 1 edge.
